// File: rtl/instruction_ctrl_pkg.sv
// Shared types and constants for the six-instruction processor control unit.
// Opcode/state encodings, ALU selects and instruction field bit positions.
package instruction_ctrl_pkg;

  typedef enum logic [3:0] {
    OpNoop  = 4'd0,
    OpStore = 4'd1,
    OpLoad  = 4'd2,
    OpAdd   = 4'd3,
    OpSub   = 4'd4,
    OpHalt  = 4'd5
  } opcode_e;

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam int unsigned OpMsb     = 15;
  localparam int unsigned OpLsb     = 12;
  localparam int unsigned RaMsb     = 11;
  localparam int unsigned RaLsb     = 8;
  localparam int unsigned RbMsb     = 7;
  localparam int unsigned RbLsb     = 4;
  localparam int unsigned RdMsb     = 3;
  localparam int unsigned RdLsb     = 0;
  localparam int unsigned LdAddrMsb = 11;
  localparam int unsigned LdAddrLsb = 4;
  localparam int unsigned StAddrMsb = 7;
  localparam int unsigned StAddrLsb = 0;

endpackage

// File: rtl/instruction_controller.sv
// Moore control unit: fetches into an internal IR, decodes, sequences datapath strobes.
// Define CTRL_ILLEGAL_TRAP_EN to send unused opcodes 6..15 to HALT instead of NOOP.
module instruction_controller
  import instruction_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned RADDR_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] IR_in,
  output logic               PC_Clr,
  output logic               PC_Up,
  output logic               IR_Ld,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_Addr,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_Ra_Addr,
  output logic [RADDR_W-1:0] RF_Rb_Addr,
  output logic [2:0]         ALU_s0,
  output logic [3:0]         State_out
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StInit;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = ALU_PASS;
    State_out  = state_q;

    unique case (state_q)
      StInit: begin
        PC_Clr  = 1'b1;
        state_d = StFetch;
      end
      StFetch: begin
        // IR and PC advance on the same edge, so IR_in is the word at the old PC.
        IR_Ld   = 1'b1;
        PC_Up   = 1'b1;
        ir_d    = IR_in;
        state_d = StDecode;
      end
      StDecode: begin
        case (ir_q[OpMsb:OpLsb])
          OpNoop:  state_d = StNoop;
          OpStore: state_d = StStore;
          OpLoad:  state_d = StLoadA;
          OpAdd:   state_d = StAdd;
          OpSub:   state_d = StSub;
          OpHalt:  state_d = StHalt;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: state_d = StHalt;
`else
          default: state_d = StNoop;
`endif
        endcase
      end
      StNoop: state_d = StFetch;
      StLoadA: begin
        // Extra cycle covers the synchronous RAM read latency.
        D_Addr  = ir_q[LdAddrMsb:LdAddrLsb];
        RF_s    = 1'b1;
        state_d = StLoadB;
      end
      StLoadB: begin
        D_Addr    = ir_q[LdAddrMsb:LdAddrLsb];
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[RdMsb:RdLsb];
        RF_W_en   = 1'b1;
        state_d   = StFetch;
      end
      StStore: begin
        RF_Ra_Addr = ir_q[RaMsb:RaLsb];
        D_Addr     = ir_q[StAddrMsb:StAddrLsb];
        D_Wr       = 1'b1;
        state_d    = StFetch;
      end
      StAdd, StSub: begin
        RF_Ra_Addr = ir_q[RaMsb:RaLsb];
        RF_Rb_Addr = ir_q[RbMsb:RbLsb];
        RF_W_Addr  = ir_q[RdMsb:RdLsb];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == StAdd) ? ALU_ADD : ALU_SUB;
        state_d    = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Bench for instruction_controller: directed and random instructions against a
// per-instruction expected-cycle model built from the opcode rules.
module tb_instruction_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IR_in;
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, State_out;
  logic [2:0]  ALU_s0;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  always #5 Clock = ~Clock;

  instruction_controller dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IR_in      (IR_in),
    .PC_Clr     (PC_Clr),
    .PC_Up      (PC_Up),
    .IR_Ld      (IR_Ld),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .State_out  (State_out)
  );

  // Expected output vector: state, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s,
  // RF_W_Addr, RF_W_en, Ra, Rb, ALU_s0.
  function automatic logic [32:0] vec(int st, bit clr, bit up, bit ld, logic [7:0] da,
                                      bit wr, bit rfs, logic [3:0] wa, bit wen,
                                      logic [3:0] ra, logic [3:0] rb, logic [2:0] alu);
    logic [3:0] s;
    s = st[3:0];
    return {s, clr, up, ld, da, wr, rfs, wa, wen, ra, rb, alu};
  endfunction

  function automatic logic [32:0] idle(int st);
    return vec(st, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0);
  endfunction

  // Queue the execute-phase cycles of one instruction; returns 1 when it halts.
  function automatic bit plan(logic [15:0] instr);
    int op;
    op = int'(instr[15:12]);
    if (op == 0) exp_q.push_back(idle(3));
    else if (op == 1)
      exp_q.push_back(vec(6, 0, 0, 0, instr[7:0], 1, 0, 4'h0, 0, instr[11:8], 4'h0, 3'd0));
    else if (op == 2) begin
      exp_q.push_back(vec(4, 0, 0, 0, instr[11:4], 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
      exp_q.push_back(vec(5, 0, 0, 0, instr[11:4], 0, 1, instr[3:0], 1, 4'h0, 4'h0, 3'd0));
    end else if (op == 3 || op == 4)
      exp_q.push_back(vec(op + 4, 0, 0, 0, 8'h0, 0, 0, instr[3:0], 1, instr[11:8],
                          instr[7:4], (op == 3) ? 3'd1 : 3'd2));
    else if (op == 5) return 1'b1;
    else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      return 1'b1;
`else
      exp_q.push_back(idle(3));
`endif
    end
    return 1'b0;
  endfunction

  task automatic check(string tag, logic [32:0] e);
    logic [32:0] obs;
    obs = {State_out, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0};
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(int n);
    Reset = 1'b1;
    repeat (n) begin
      tick();
      check("reset_init", vec(0, 1, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    end
    Reset = 1'b0;
    tick();
  endtask

  // Entered in FETCH; leaves in FETCH (after a reset if the instruction halts).
  task automatic run_instr(logic [15:0] instr);
    bit halted;
    IR_in = instr;
    check("fetch", vec(1, 0, 1, 1, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    tick();
    IR_in = 16'($urandom);
    check("decode", idle(2));
    tick();
    halted = plan(instr);
    if (halted) begin
      repeat (20) begin
        IR_in = 16'($urandom);
        check("halt", idle(9));
        tick();
      end
      do_reset(1);
    end else begin
      while (exp_q.size() > 0) begin
        IR_in = 16'($urandom);
        check("exec", exp_q.pop_front());
        tick();
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    IR_in = 16'h0000;
    do_reset(2);

    run_instr(16'h21A3);
    run_instr(16'h3125);
    run_instr(16'h4125);
    run_instr(16'h147F);
    run_instr(16'h0000);
    run_instr(16'hF000);

    for (int i = 0; i < 60; i++) run_instr(16'($urandom));

    run_instr(16'h5000);

    // Reset while in LOAD_A must abort without an RF write.
    IR_in = 16'h2ABC;
    check("rl_fetch", vec(1, 0, 1, 1, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    tick();
    check("rl_decode", idle(2));
    tick();
    check("rl_loada", vec(4, 0, 0, 0, 8'hAB, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    Reset = 1'b1;
    tick();
    check("rl_init", vec(0, 1, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0));
    n_cmp++;
    assert (dut.ir_q === 16'h0000) else begin
      n_err++;
      $error("FAIL rl_ir: observed %h expected %h", dut.ir_q, 16'h0000);
    end
    Reset = 1'b0;
    tick();
    run_instr(16'h3456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
